// File: rtl/router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkg : header field layout, byte width and FSM states shared by router blocks
// Revision  : 1.0
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int BYTE_W      = 8;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    BODY     = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkt_reader_if : FIFO read handshake plus packet stream towards local logic
// Revision            : 1.0
// ---------------------------------------------------------------------------
interface router_pkt_reader_if;
  import router_pkg::*;

  logic                vld_out;
  logic [BYTE_W-1:0]   data_out;
  logic                sink_ready;
  logic                read_enb;
  logic [BYTE_W-1:0]   pkt_data;
  logic                pkt_valid;
  logic                pkt_sop;
  logic                pkt_eop;
  logic [LEN_W-1:0]    pkt_len;
  logic                pkt_done;
  logic                parity_err;
  logic                addr_err;
  logic                timeout_err;
  logic                busy;

  modport master (
    output vld_out, data_out, sink_ready,
    input  read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_len,
           pkt_done, parity_err, addr_err, timeout_err, busy
  );

  modport slave (
    input  vld_out, data_out, sink_ready,
    output read_enb, pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_len,
           pkt_done, parity_err, addr_err, timeout_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/router_parity_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_parity_acc : XOR accumulator with clear/load/accumulate and compare
// Revision          : 1.0
// ---------------------------------------------------------------------------
module router_parity_acc #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic         i_clr,
  input  wire logic         i_load,
  input  wire logic         i_acc,
  input  wire logic [W-1:0] i_data,
  input  wire logic [W-1:0] i_cmp,
  output logic              o_mismatch
);

  logic [W-1:0] r_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_data;
    end else if (i_acc) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_mismatch = (r_acc != i_cmp);

endmodule
`default_nettype wire

// File: rtl/router_pkt_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkt_reader : drains one router output FIFO, streams the packet, checks parity/addr
// Revision          : 1.0
// ---------------------------------------------------------------------------
module router_pkt_reader
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ID        = 2'd0,
  parameter int                    TIMEOUT_CYCLES = 30,
  parameter int                    CNT_W          = 5
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  router_pkt_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [LEN_W:0]   c_len_one = (LEN_W+1)'(1);

  state_t                  r_state;
  logic [LEN_W:0]          r_rd_left;
  logic [LEN_W:0]          r_rcv_left;
  logic                    r_inflight;
  logic [HDR_ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]        r_cnt;
  logic [BYTE_W-1:0]       r_pkt_data;
  logic                    r_pkt_valid;
  logic                    r_pkt_sop;
  logic                    r_pkt_eop;
  logic [LEN_W-1:0]        r_pkt_len;
  logic                    r_pkt_done;
  logic                    r_parity_err;
  logic                    r_addr_err;
  logic                    r_timeout_err;
  logic                    r_busy;

  logic                    w_read_enb;
  logic                    w_arrive;
  logic                    w_last;
  logic                    w_abort;
  logic                    w_mismatch;
  logic [CNT_W-1:0]        w_cnt_nxt;

  always_comb begin
    w_read_enb = 1'b0;
    case (r_state)
      IDLE:    w_read_enb = bus.vld_out & bus.sink_ready;
      BODY:    w_read_enb = bus.vld_out & bus.sink_ready & (r_rd_left != '0);
      default: w_read_enb = 1'b0;
    endcase
  end

  // A byte lands on data_out the cycle after a BODY read; the last one is parity
  assign w_arrive  = (r_state == BODY) & r_inflight;
  assign w_last    = w_arrive & (r_rcv_left == c_len_one);
  assign w_cnt_nxt = bus.vld_out ? '0 : ((r_cnt == c_timeout) ? r_cnt : r_cnt + c_cnt_one);
  assign w_abort   = (r_state == BODY) & ~bus.vld_out & (w_cnt_nxt == c_timeout) & ~r_inflight;

  router_parity_acc #(.W(BYTE_W)) u_par (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr      ((r_state == DONE) | w_abort),
    .i_load     (r_state == HDR_WAIT),
    .i_acc      (w_arrive & ~w_last),
    .i_data     (bus.data_out),
    .i_cmp      (bus.data_out),
    .o_mismatch (w_mismatch)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_rd_left     <= '0;
      r_rcv_left    <= '0;
      r_inflight    <= 1'b0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_pkt_data    <= '0;
      r_pkt_valid   <= 1'b0;
      r_pkt_sop     <= 1'b0;
      r_pkt_eop     <= 1'b0;
      r_pkt_len     <= '0;
      r_pkt_done    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_addr_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pkt_valid   <= 1'b0;
      r_pkt_sop     <= 1'b0;
      r_pkt_eop     <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_inflight    <= (r_state == BODY) & w_read_enb;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_read_enb) begin
            r_state <= HDR_WAIT;
            r_busy  <= 1'b1;
          end
        end
        HDR_WAIT: begin
          r_pkt_data  <= bus.data_out;
          r_pkt_valid <= 1'b1;
          r_pkt_sop   <= 1'b1;
          r_pkt_len   <= hdr_len(bus.data_out);
          r_addr      <= hdr_addr(bus.data_out);
          r_rd_left   <= {1'b0, hdr_len(bus.data_out)} + c_len_one;
          r_rcv_left  <= {1'b0, hdr_len(bus.data_out)} + c_len_one;
          r_cnt       <= '0;
          r_state     <= BODY;
        end
        BODY: begin
          r_cnt <= w_cnt_nxt;
          if (w_read_enb) begin
            r_rd_left <= r_rd_left - c_len_one;
          end
          if (w_arrive) begin
            r_pkt_data  <= bus.data_out;
            r_pkt_valid <= 1'b1;
            r_rcv_left  <= r_rcv_left - c_len_one;
            if (w_last) begin
              r_pkt_eop    <= 1'b1;
              r_parity_err <= w_mismatch;
              r_addr_err   <= (r_addr != PORT_ID);
              r_pkt_done   <= 1'b1;
              r_state      <= DONE;
            end
          end
          if (w_abort) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        DONE: begin
          r_parity_err <= 1'b0;
          r_addr_err   <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.read_enb    = w_read_enb & resetn;
  assign bus.pkt_data    = r_pkt_data;
  assign bus.pkt_valid   = r_pkt_valid;
  assign bus.pkt_sop     = r_pkt_sop;
  assign bus.pkt_eop     = r_pkt_eop;
  assign bus.pkt_len     = r_pkt_len;
  assign bus.pkt_done    = r_pkt_done;
  assign bus.parity_err  = r_parity_err;
  assign bus.addr_err    = r_addr_err;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_pkt_reader : FIFO model driver, packet-level reference model and scoreboard
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_router_pkt_reader;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [5:0] len;
  } exp_t;

  logic clk;
  logic resetn;
  router_pkt_reader_if bus ();

  router_pkt_reader #(
    .PORT_ID        (2'd0),
    .TIMEOUT_CYCLES (30),
    .CNT_W          (5)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         t_rd  = 0;
  int         smode = 0;
  int         to_exp = 0;
  bit         lat_chk = 0;
  exp_t       eq[$];
  logic [1:0] dq[$];
  logic [7:0] fq[$];
  logic [7:0] pl[$];

  // FIFO model: one-cycle read latency, vld_out = not empty
  initial begin
    logic re_s;
    bus.vld_out    = 1'b0;
    bus.data_out   = 8'h00;
    bus.sink_ready = 1'b0;
    forever begin
      @(negedge clk);
      re_s = bus.read_enb;
      @(posedge clk);
      #1;
      if (re_s && fq.size() > 0) bus.data_out = fq.pop_front();
      bus.vld_out = (fq.size() != 0);
      case (smode)
        0:       bus.sink_ready = 1'b1;
        1:       bus.sink_ready = ~bus.sink_ready;
        default: bus.sink_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t       e;
    logic [1:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.read_enb) begin
        total++;
        if (!bus.vld_out) begin
          bad++;
          $display("FAIL rd_vld: read_enb=1 with vld_out=%0b at cyc %0d", bus.vld_out, cyc);
        end
        if (!bus.busy) t_rd = cyc;
      end
      if (bus.pkt_valid) begin
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL byte_extra: got data=%h sop=%0b eop=%0b, expected none", bus.pkt_data, bus.pkt_sop, bus.pkt_eop);
        end else begin
          e = eq.pop_front();
          if ({bus.pkt_data, bus.pkt_sop, bus.pkt_eop, bus.pkt_len} !== e) begin
            bad++;
            $display("FAIL byte: got d=%h sop=%0b eop=%0b len=%0d, expected d=%h sop=%0b eop=%0b len=%0d",
                     bus.pkt_data, bus.pkt_sop, bus.pkt_eop, bus.pkt_len, e.d, e.sop, e.eop, e.len);
          end
        end
      end
      if (bus.pkt_done) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_extra: got pkt_done, expected none");
        end else begin
          d = dq.pop_front();
          if ({bus.parity_err, bus.addr_err} !== d) begin
            bad++;
            $display("FAIL done_flags: got par=%0b addr=%0b, expected par=%0b addr=%0b",
                     bus.parity_err, bus.addr_err, d[1], d[0]);
          end
        end
        if (lat_chk) begin
          lat_chk = 0;
          total++;
          if (cyc - t_rd != 4) begin
            bad++;
            $display("FAIL latency: got %0d cycles, expected 4", cyc - t_rd);
          end
        end
      end
      if (bus.timeout_err) begin
        total++;
        if (to_exp == 0) begin
          bad++;
          $display("FAIL timeout_extra: got timeout_err, expected none");
        end else begin
          to_exp--;
        end
      end
    end
  end

  // Reference model: packet = header, len payload bytes, XOR parity byte.
  // par_mode 0 correct parity, 1 forced value, 2 correct ^ par_val.
  // first_n >= 0: push first_n bytes, pause, then rest (or never, when abort).
  task automatic queue_pkt(input logic [7:0] hdr, input int par_mode, input logic [7:0] par_val,
                           input int first_n, input int pause, input bit abort, input bit gaps);
    logic [7:0] x;
    logic [7:0] par;
    logic [7:0] bytes[$];
    int         n;
    int         nexp;
    exp_t       e;
    n = int'(hdr[7:2]);
    x = hdr;
    foreach (pl[i]) x ^= pl[i];
    par = (par_mode == 0) ? x : (par_mode == 1) ? par_val : (x ^ par_val);
    bytes.push_back(hdr);
    for (int i = 0; i < n; i++) bytes.push_back(pl[i]);
    bytes.push_back(par);
    nexp = abort ? first_n : n + 2;
    for (int i = 0; i < nexp; i++) begin
      e.d   = bytes[i];
      e.sop = (i == 0);
      e.eop = (i == n + 1);
      e.len = hdr[7:2];
      eq.push_back(e);
    end
    if (abort) to_exp++;
    else dq.push_back({par != x, hdr[1:0] != 2'd0});
    for (int i = 0; i < nexp; i++) begin
      if (first_n >= 0 && i == first_n) repeat (pause) @(posedge clk);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
      fq.push_back(bytes[i]);
    end
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k;
    for (k = 0; k < lim; k++) begin
      @(negedge clk);
      if (fq.size() == 0 && eq.size() == 0 && dq.size() == 0 && to_exp == 0 && !bus.busy) break;
    end
    if (k == lim) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d bytes/%0d dones/%0d timeouts outstanding, expected 0",
               tag, eq.size(), dq.size(), to_exp);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [27:0] v;
    v = {bus.read_enb, bus.pkt_data, bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_len,
         bus.pkt_done, bus.parity_err, bus.addr_err, bus.timeout_err, bus.busy, 3'b000};
    total++;
    if (v !== 28'h0) begin
      bad++;
      $display("FAIL %s: outputs=%h, expected 0", tag, v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    int k;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_zero("reset");
    resetn = 1'b1;

    // Nominal packet, correct parity 8'h14
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    queue_pkt(8'h10, 1, 8'h14, -1, 0, 0, 0);
    wait_idle(200, "nominal");
    total++;
    if (bus.pkt_len !== 6'd4) begin
      bad++;
      $display("FAIL pkt_len_hold: got %0d, expected 4", bus.pkt_len);
    end

    // Bad parity then a clean packet
    queue_pkt(8'h10, 1, 8'h15, -1, 0, 0, 0);
    queue_pkt(8'h10, 0, 8'h00, -1, 0, 0, 0);
    wait_idle(200, "badpar");

    // len=0 with wrong address, latency to pkt_done
    pl.delete();
    lat_chk = 1;
    queue_pkt(8'h01, 1, 8'h01, -1, 0, 0, 0);
    wait_idle(200, "len0");
    total++;
    if (lat_chk) begin
      bad++;
      $display("FAIL len0_done: got no pkt_done, expected one");
      lat_chk = 0;
    end

    // FIFO empties after two payload bytes, sink toggling
    smode = 1;
    rand_payload(4);
    queue_pkt(8'h10, 0, 8'h00, 3, 10, 0, 0);
    wait_idle(300, "stall");
    smode = 0;

    // FIFO empties after one payload byte for good -> timeout
    rand_payload(4);
    queue_pkt(8'h10, 0, 8'h00, 2, 0, 1, 0);
    wait_idle(200, "timeout");
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_timeout: got %0b, expected 0", bus.busy);
    end
    rand_payload(3);
    queue_pkt(8'h0C, 0, 8'h00, -1, 0, 0, 0);
    wait_idle(200, "post_timeout");

    // Reset mid-BODY, then a fresh len=2 packet
    rand_payload(8);
    queue_pkt(8'h20, 0, 8'h00, -1, 0, 0, 0);
    for (k = 0; k < 50 && !bus.busy; k++) @(negedge clk);
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_zero("mid_reset");
    eq.delete();
    dq.delete();
    fq.delete();
    to_exp = 0;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    rand_payload(2);
    queue_pkt(8'h08, 0, 8'h00, -1, 0, 0, 0);
    wait_idle(200, "after_reset");

    // Randomized back-to-back traffic
    for (int p = 0; p < 40; p++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 10);
      rand_payload(len);
      smode = $urandom_range(0, 2);
      queue_pkt({6'(len), 2'($urandom_range(0, 3))},
                ($urandom_range(0, 3) == 0) ? 2 : 0, 8'($urandom_range(1, 255)),
                -1, 0, 0, 1);
    end
    wait_idle(20000, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
